arb_wrr: RTL
============

# arb_wrr

Weighted round-robin arbiter, the parametrised successor to `arb_rr`. It grants one of `WIDTH` requesters at a time and holds the grant for up to `weight` accepted transfers. Rotating priority then moves past the last owner. It sits in front of a shared downstream port that uses a ready handshake, and it supports per-requester weights from a static configuration.

## Interface
Parameters:
- `WIDTH`, 4: number of requesters (≥2).
- `WEIGHT_W`, 4: width of each weight field.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `v_vld`, input, `WIDTH`: request per requester; level-held until served.
- `v_weight`, input, `WIDTH*WEIGHT_W`: per-requester weight; field i is `[i*WEIGHT_W +: WEIGHT_W]`; quasi-static.
- `ds_rdy`, input, 1: downstream accepts a transfer this cycle.
- `v_grant`, output, `WIDTH`: registered one-hot grant; all zero when idle.
- `grant_idx`, output, `$clog2(WIDTH)`: index of the owner; valid only when `grant_vld`.
- `grant_vld`, output, 1: `|v_grant`.
- `v_lock`, input, `WIDTH`: present only with `ARB_WRR_LOCK_EN`.

## Operation
- **State.** FSM with states IDLE and OWN. The block also holds:
  - rotating pointer `ptr` (`$clog2(WIDTH)` bits);
  - credit counter `cred` (`WEIGHT_W` bits);
  - owner register.
- **Pick.** Select the first i with `v_vld[i]=1`, searching from `ptr` upward and wrapping at `WIDTH-1`→0.
- **IDLE.**
  - If any `v_vld` is set: the picked i becomes owner. Load `cred = (w_i==0) ? 1 : w_i`. Go to OWN.
  - Otherwise stay in IDLE.
- **OWN.**
  - **Transfer:** `v_vld[owner] & ds_rdy` in the same cycle. Each transfer decrements `cred`.
  - **Release:** when a transfer occurs with `cred==1`, or when `v_vld[owner]==0`, which is a withdrawal.
  - **On release:**
    - Set `ptr = owner+1`, wrapping.
    - Re-arbitrate in the same cycle using the updated pointer, with the releasing owner's request excluded. The new owner is granted on the next edge, so back-to-back grants have no bubble.
    - If there is no other request and the released owner still requests, the released owner is re-granted.
    - If there is no request at all, go to IDLE.
- **Weights.** A change to `v_weight` takes effect at the next credit load only.
- **Timing of requests.** A request raised while another requester owns the grant waits for the release. Starvation is bounded at Σ weights transfers.

## Timing
- **Reset values:**
  - `v_grant=0`, `grant_vld=0`, `grant_idx=0`;
  - `ptr=0`, `cred=0`, state IDLE.
- **Latency.** Request to grant is 1 cycle: `v_vld` at edge N gives `v_grant` visible after edge N+1.
- **Outputs.** `v_grant` changes only on clock edges and never depends combinationally on inputs.
- **Reset mid-grant.** Reset clears the grant immediately (asynchronously), and `ptr` returns to 0.
- **Simultaneous events.** A withdrawal in the same cycle as `cred==1` counts as a single release.
- **Stalled downstream.** `ds_rdy=0` holds both the grant and `cred`.

## Configuration
`ARB_WRR_LOCK_EN`:
- **Defined:**
  - The `v_lock` port exists.
  - A transfer with `v_lock[owner]=1` never causes a credit release: `cred` saturates at 1 and the grant is held.
  - Release waits for the first transfer with lock low and `cred==1`. A withdrawal still releases.
- **Undefined:** the port is absent and behaviour is as described above.

## Structure
- **Package `arb_pkg`:**
  - `arb_state_e` (IDLE, OWN);
  - helper function `onehot2idx`.
- **Sub-module `arb_rr_pick`:** combinational rotating-priority picker with inputs `req[WIDTH]`, `ptr`, and outputs `onehot`, `idx`, `any`. Instantiated once.
- **Top level:** FSM, credit counter, pointer and lock handling.

## Test plan
All scenarios use WIDTH=4.
1. **Equal weights.** Weights all 1, `v_vld=4'b1111`, `ds_rdy=1`. The grant rotates 0001→0010→0100→1000→0001, one new owner per cycle with no bubbles.
2. **Unequal weights.** Weights {w0=3, w1=1, w2=2, w3=0}, all requesting, `ds_rdy=1`. Grant sequence: 0,0,0,1,2,2,3 (w=0 treated as 1), then repeats.
3. **Stall and withdrawal.** Owner 2 with w=4:
   - `ds_rdy=0` for 5 cycles: grant and `cred` are held.
   - Then `v_vld[2]` drops: release, and the next requester at index ≥3 is granted one cycle later.
4. **Sole requester and idle.** Single request `v_vld=4'b0100`, w2=2. The grant stays on 2 indefinitely, since it is re-granted while it is the sole requester. Dropping the request gives `v_grant=0` after one edge.
5. **Reset mid-grant.** Assert `rst` mid-grant with owner 3. `v_grant` goes to 0 without a clock edge. After release with all requesting, the first grant is 0001.
6. **Lock (`ARB_WRR_LOCK_EN`).** Owner 1 with w=1 and `v_lock[1]=1` for 6 transfers holds the grant throughout. With lock low on the 7th transfer, the grant passes to requester 2.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    function automatic int unsigned onehot2idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational rotating-priority picker: first set request at or above ptr,
// wrapping to the lowest set request when nothing at or above ptr is pending.
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]         req,
    input  logic [$clog2(WIDTH)-1:0] ptr,
    output logic [WIDTH-1:0]         onehot,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     any
);

    localparam int IW = $clog2(WIDTH);

    logic [WIDTH-1:0] w_ge;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_sel;

    always_comb begin
        w_ge = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_ge[i] = (i >= int'(ptr));
        end
    end

    assign w_hi   = req & w_ge;
    assign w_sel  = (|w_hi) ? w_hi : req;
    // Isolate the lowest set bit of the selected half.
    assign onehot = w_sel & (-w_sel);
    assign idx    = IW'(onehot2idx(32'(onehot)));
    assign any    = |req;

endmodule

// File: rtl/arb_wrr.sv
// Weighted round-robin arbiter with credit-limited grant ownership.
// Optional per-requester lock input enabled by defining ARB_WRR_LOCK_EN.
//
//   state | meaning
//   IDLE  | no owner, grant low, pick on any request
//   OWN   | grant held by r_owner until credit release or withdrawal
module arb_wrr
    import arb_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int WEIGHT_W = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            v_vld,
    input  logic [WIDTH*WEIGHT_W-1:0]   v_weight,
    input  logic                        ds_rdy,
`ifdef ARB_WRR_LOCK_EN
    input  logic [WIDTH-1:0]            v_lock,
`endif
    output logic [WIDTH-1:0]            v_grant,
    output logic [$clog2(WIDTH)-1:0]    grant_idx,
    output logic                        grant_vld
);

    localparam int IW = $clog2(WIDTH);

    arb_state_e            r_state, w_state_nxt;
    logic [WIDTH-1:0]      r_grant, w_grant_nxt;
    logic [IW-1:0]         r_owner, w_owner_nxt;
    logic [IW-1:0]         r_ptr, w_ptr_nxt;
    logic [WEIGHT_W-1:0]   r_cred, w_cred_nxt;

    logic [IW-1:0]         w_ptr_inc;
    logic [WIDTH-1:0]      w_pick_req;
    logic [IW-1:0]         w_pick_ptr;
    logic [WIDTH-1:0]      w_pick_oh;
    logic [IW-1:0]         w_pick_idx;
    logic                  w_pick_any;
    logic                  w_own_vld;
    logic                  w_lock_own;
    logic                  w_cred_one;
    logic                  w_xfer;
    logic                  w_rel;

    // Zero weight still grants one transfer.
    function automatic logic [WEIGHT_W-1:0] cred_load(
        input logic [IW-1:0]               idx,
        input logic [WIDTH*WEIGHT_W-1:0]   wv
    );
        logic [WEIGHT_W-1:0] f_w;
        f_w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (idx == IW'(i)) f_w = wv[i*WEIGHT_W +: WEIGHT_W];
        end
        return (f_w == '0) ? WEIGHT_W'(1) : f_w;
    endfunction

`ifdef ARB_WRR_LOCK_EN
    assign w_lock_own = v_lock[r_owner];
`else
    assign w_lock_own = 1'b0;
`endif

    assign w_ptr_inc  = (r_owner == IW'(WIDTH - 1)) ? '0 : r_owner + IW'(1);
    assign w_own_vld  = v_vld[r_owner];
    assign w_cred_one = (r_cred == WEIGHT_W'(1));
    assign w_xfer     = w_own_vld & ds_rdy;
    assign w_rel      = (w_xfer & w_cred_one & ~w_lock_own) | ~w_own_vld;

    // In OWN the picker looks ahead from the post-release pointer and skips
    // the current owner, so a release can hand over on the very next edge.
    always_comb begin
        w_pick_req = v_vld;
        w_pick_ptr = r_ptr;
        if (r_state == OWN) begin
            w_pick_req = v_vld & ~r_grant;
            w_pick_ptr = w_ptr_inc;
        end
    end

    arb_rr_pick #(
        .WIDTH (WIDTH)
    ) u_pick (
        .req    (w_pick_req),
        .ptr    (w_pick_ptr),
        .onehot (w_pick_oh),
        .idx    (w_pick_idx),
        .any    (w_pick_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_cred_nxt  = r_cred;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = OWN;
                    w_grant_nxt = w_pick_oh;
                    w_owner_nxt = w_pick_idx;
                    w_cred_nxt  = cred_load(w_pick_idx, v_weight);
                end
            end
            OWN: begin
                if (w_rel) begin
                    w_ptr_nxt = w_ptr_inc;
                    if (w_pick_any) begin
                        w_grant_nxt = w_pick_oh;
                        w_owner_nxt = w_pick_idx;
                        w_cred_nxt  = cred_load(w_pick_idx, v_weight);
                    end else if (w_own_vld) begin
                        w_cred_nxt  = cred_load(r_owner, v_weight);
                    end else begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                        w_cred_nxt  = '0;
                    end
                end else if (w_xfer && !w_cred_one) begin
                    // A locked transfer at cred==1 leaves the counter parked at 1.
                    w_cred_nxt = r_cred - WEIGHT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_cred  <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_cred  <= w_cred_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign v_grant   = r_grant;
    assign grant_idx = r_owner;
    assign grant_vld = |r_grant;

endmodule
